// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage program counter sequencer.
// Operation encoding used on the op port and by the next-PC logic.
package pc_seq_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_REL  = 3'd2,
        PC_ABS  = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5
    } pc_op_e;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; pushes when full and pops when empty are dropped.
// Top-of-stack is a combinational read of the registered depth; contents are not reset.
module ret_stack #(
    parameter int W = 12,
    parameter int N = 4,
    localparam int DW = $clog2(N + 1),
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [N];
    logic [DW-1:0] depth_q, depth_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          do_push, do_pop;

    assign full    = (depth_q == DW'(N));
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));
    assign dout    = empty ? '0 : mem_q[rd_idx];
    assign depth   = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Storage needs no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter: INC/REL/ABS jumps plus CALL/RET via ret_stack.
// One-cycle op-to-prog_ctr latency; stall freezes PC, stack and sticky flags.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int          D       = 12,
    parameter int          SD      = 4,
    parameter logic [D-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [PC_OP_W-1:0]         op,
    input  logic [D-1:0]               target,
    output logic [D-1:0]               prog_ctr,
    output logic [$clog2(SD+1)-1:0]    stack_depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_ovf,
    output logic                       stack_unf
);

    logic [D-1:0] pc_q, pc_d, pc_inc, tos;
    logic         ovf_q, ovf_d, unf_q, unf_d;
    logic         push, pop;

    assign pc_inc = pc_q + D'(1);

    ret_stack #(.W(D), .N(SD)) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (tos),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (!stall) begin
            case (pc_op_e'(op))
                PC_HOLD: pc_d = pc_q;
                PC_INC:  pc_d = pc_inc;
                PC_REL:  pc_d = pc_q + target;
                PC_ABS:  pc_d = target;
                PC_CALL: begin
                    pc_d = target;
                    push = 1'b1;
                    if (stack_full) ovf_d = 1'b1;
                end
                PC_RET: begin
                    // Empty-stack return degrades to a plain increment.
                    if (stack_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d = tos;
                        pop  = 1'b1;
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RST_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign prog_ctr  = pc_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with D=12, SD=4, RST_VAL=0.
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [11:0] target = 12'h000;
    logic [11:0] prog_ctr;
    logic [2:0]  stack_depth;
    logic        stack_full, stack_empty, stack_ovf, stack_unf;

    int n_cmp = 0;
    int n_bad = 0;

    pc_seq #(.D(12), .SD(4), .RST_VAL(12'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .op          (op),
        .target      (target),
        .prog_ctr    (prog_ctr),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [11:0] t);
        op = o;
        target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        op = 3'(PC_HOLD);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [11:0] ret_exp [4] = '{12'h103, 12'h102, 12'h101, 12'h001};

    initial begin
        // Reset state and plain increments
        do_reset();
        chk("rst_pc", 32'(prog_ctr), 32'h000);
        chk("rst_depth", 32'(stack_depth), 32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk("rst_full", 32'(stack_full), 32'd0);
        chk("rst_ovf", 32'(stack_ovf), 32'd0);
        chk("rst_unf", 32'(stack_unf), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(3'(PC_INC), 12'h000);
            chk($sformatf("inc%0d", i), 32'(prog_ctr), 32'(i));
        end
        chk("inc_empty", 32'(stack_empty), 32'd1);
        chk("inc_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
        step(3'(PC_HOLD), 12'h555);
        chk("hold", 32'(prog_ctr), 32'h003);

        // Relative, absolute, wrap, undefined codes
        step(3'(PC_ABS), 12'h010);
        chk("abs", 32'(prog_ctr), 32'h010);
        step(3'(PC_REL), 12'hFFC);
        chk("rel_neg", 32'(prog_ctr), 32'h00C);
        step(3'(PC_REL), 12'h005);
        chk("rel_pos", 32'(prog_ctr), 32'h011);
        step(3'(PC_ABS), 12'h002);
        step(3'(PC_REL), 12'hFFE);
        chk("rel_zero", 32'(prog_ctr), 32'h000);
        step(3'(PC_ABS), 12'hFFF);
        step(3'(PC_INC), 12'h000);
        chk("inc_wrap", 32'(prog_ctr), 32'h000);
        step(3'd6, 12'h777);
        chk("op6", 32'(prog_ctr), 32'h001);
        step(3'd7, 12'h777);
        chk("op7", 32'(prog_ctr), 32'h002);

        // Simple call/return and back-to-back call/ret
        step(3'(PC_ABS), 12'h020);
        step(3'(PC_CALL), 12'h100);
        chk("call_pc", 32'(prog_ctr), 32'h100);
        chk("call_depth", 32'(stack_depth), 32'd1);
        step(3'(PC_INC), 12'h000);
        chk("call_inc", 32'(prog_ctr), 32'h101);
        step(3'(PC_RET), 12'h000);
        chk("ret_pc", 32'(prog_ctr), 32'h021);
        chk("ret_depth", 32'(stack_depth), 32'd0);
        step(3'(PC_ABS), 12'h030);
        step(3'(PC_CALL), 12'h200);
        step(3'(PC_RET), 12'h000);
        chk("callret_pc", 32'(prog_ctr), 32'h031);

        // Nested calls past capacity
        step(3'(PC_ABS), 12'h000);
        for (int i = 0; i < 5; i++) step(3'(PC_CALL), 12'(12'h100 + i));
        chk("nest_pc", 32'(prog_ctr), 32'h104);
        chk("nest_full", 32'(stack_full), 32'd1);
        chk("nest_depth", 32'(stack_depth), 32'd4);
        chk("nest_ovf", 32'(stack_ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(3'(PC_RET), 12'h000);
            chk($sformatf("lifo%0d", i), 32'(prog_ctr), 32'(ret_exp[i]));
        end
        chk("lifo_empty", 32'(stack_empty), 32'd1);
        chk("lifo_ovf_sticky", 32'(stack_ovf), 32'd1);

        // Underflow and stickiness
        do_reset();
        chk("rst2_ovf", 32'(stack_ovf), 32'd0);
        step(3'(PC_ABS), 12'h050);
        step(3'(PC_RET), 12'h000);
        chk("unf_pc", 32'(prog_ctr), 32'h051);
        chk("unf_flag", 32'(stack_unf), 32'd1);
        chk("unf_depth", 32'(stack_depth), 32'd0);
        for (int i = 0; i < 10; i++) step(3'(PC_INC), 12'h000);
        chk("unf_sticky_pc", 32'(prog_ctr), 32'h05B);
        chk("unf_sticky", 32'(stack_unf), 32'd1);
        chk("unf_no_ovf", 32'(stack_ovf), 32'd0);
        do_reset();
        chk("unf_clr", 32'(stack_unf), 32'd0);

        // Stall freezes everything; reset overrides stall
        step(3'(PC_CALL), 12'h300);
        step(3'(PC_CALL), 12'h310);
        chk("pre_stall_depth", 32'(stack_depth), 32'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(3'(PC_CALL), 12'h555);
            chk($sformatf("stall_pc%0d", i), 32'(prog_ctr), 32'h310);
            chk($sformatf("stall_depth%0d", i), 32'(stack_depth), 32'd2);
        end
        step(3'(PC_RET), 12'h000);
        chk("stall_ret_pc", 32'(prog_ctr), 32'h310);
        chk("stall_unf", 32'(stack_unf), 32'd0);
        op = 3'(PC_RET);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_stall_pc", 32'(prog_ctr), 32'h000);
        chk("rst_stall_depth", 32'(stack_depth), 32'd0);
        reset = 1'b1;
        stall = 1'b0;
        step(3'(PC_RET), 12'h000);
        chk("post_rst_ret_pc", 32'(prog_ctr), 32'h001);
        chk("post_rst_ret_unf", 32'(stack_unf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised next-generation program counter for the processor fetch stage.
- Supports sequential increment, relative (signed) and absolute jumps, and subroutine call/return through an internal hardware return-address stack.
- Has a stall/hold input.
- Drives the instruction-memory address each cycle and reports stack status and sticky error flags to control/debug logic.

Parameters:
- D, 12: program-counter and jump-target width in bits.
- SD, 4: return-address stack depth in entries; must be ≥ 1.
- RST_VAL, 0: prog_ctr value loaded on reset, D bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- stall  input  1  when 1, all state holds; op is ignored.
- op  input  3  operation select, encoded per pc_seq_pkg::pc_op_e.
- target  input  D  signed two's-complement offset for REL; absolute address for ABS/CALL.
- prog_ctr  output  D  current program counter (registered).
- stack_depth  output  $clog2(SD+1)  number of valid stack entries.
- stack_full  output  1  stack_depth == SD.
- stack_empty  output  1  stack_depth == 0.
- stack_ovf  output  1  sticky: a CALL occurred while the stack was full.
- stack_unf  output  1  sticky: a RET occurred while the stack was empty.

Behaviour:
- Reset (reset==0 at a rising clk):
  - prog_ctr <= RST_VAL; stack_depth <= 0; stack_ovf <= 0; stack_unf <= 0.
  - Stack contents are don't-care.
  - Reset has priority over stall and op.
  - Reset asserted mid-sequence (e.g. with a pending RET) discards all stack state.
- Priority: reset > stall > op.
- Ops (pc_op_e), each taking effect on the next rising edge; 1-cycle latency from op to prog_ctr:
  - HOLD (0): prog_ctr unchanged.
  - INC (1): prog_ctr <= prog_ctr + 1.
  - REL (2): prog_ctr <= prog_ctr + target. target is sign-interpreted, result taken modulo 2^D. Example, D=12: 0x002 + 0xFFE = 0x000.
  - ABS (3): prog_ctr <= target.
  - CALL (4): push (prog_ctr + 1) mod 2^D, then prog_ctr <= target.
  - RET (5): prog_ctr <= top-of-stack, then pop.
  - Codes 6 and 7: treated as INC.
- Wrap: INC at all-ones yields 0. No overflow flag for prog_ctr arithmetic.
- Stack is a LIFO; stack_depth increments on a successful push and decrements on a successful pop.
- CALL with stack full:
  - Jump is still taken; the push is dropped; stack_depth stays SD.
  - stack_ovf <= 1.
- RET with stack empty:
  - prog_ctr <= prog_ctr + 1 (behaves as INC).
  - stack_unf <= 1; stack_depth stays 0.
- Sticky flags clear only on reset.
- A CALL immediately followed by a RET returns to the address after the CALL, with no bubble.
- stall==1 freezes prog_ctr, the stack, and the flags regardless of op.
- stack_full and stack_empty are combinational decodes of the registered stack_depth.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic [2:0] pc_op_e {PC_HOLD, PC_INC, PC_REL, PC_ABS, PC_CALL, PC_RET}.
  - Constant PC_OP_W = 3.
- Sub-module ret_stack (parameters W=D, N=SD):
  - Inputs: clk, reset, push, pop, din.
  - Outputs: dout (top), depth, full, empty.
  - Overflow/underflow suppression is handled inside ret_stack; sticky flag logic stays in pc_seq.

Test Plan:
- Reset then INC ×3 → prog_ctr 0x000, 0x001, 0x002, 0x003; stack_empty=1, both flags 0.
- prog_ctr=0x010, REL target=0xFFC (−4) → 0x00C; REL target=0x005 → 0x011; prog_ctr=0xFFF, INC → 0x000.
- prog_ctr=0x020, CALL target=0x100 → prog_ctr=0x100, depth=1; INC; RET → prog_ctr=0x021, depth=0.
- SD=4: nested CALLs ×5 from 0x000 with targets 0x100..0x104:
  - After the 5th: stack_full=1, stack_ovf=1, prog_ctr=0x104.
  - Four RETs then return in LIFO order through the four pushed addresses; the fifth return address is lost.
- RET on empty stack at prog_ctr=0x050 → prog_ctr=0x051, stack_unf=1, depth=0; flag persists through 10 INCs; clears only on reset=0.
- stall=1 with op=CALL for 3 cycles → prog_ctr and depth unchanged. reset=0 while stall=1 and depth=2 → prog_ctr=RST_VAL, depth=0 on that edge.
